// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port RAM between a CPU port (0) and a copy engine port (1).
// Optional build macro MEM_ARB_FIXED_PRIO_EN selects fixed priority (port 0 wins) instead of round-robin.
module ram_arbiter #(
    parameter int AW = 12,
    parameter int DW = 16
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          REQ0,
    input  logic          REQ1,
    input  logic          WREN0,
    input  logic          WREN1,
    input  logic [AW-1:0] ADDR0,
    input  logic [AW-1:0] ADDR1,
    input  logic [DW-1:0] WDATA0,
    input  logic [DW-1:0] WDATA1,
    output logic          ACK0,
    output logic          ACK1,
    output logic [DW-1:0] RDATA0,
    output logic [DW-1:0] RDATA1,
    output logic [AW-1:0] RAM_ADDR,
    output logic [DW-1:0] RAM_DATA,
    output logic          RAM_WREN,
    input  logic [DW-1:0] RAM_Q
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          last_q, last_d;
    logic          gid_q, gid_d;
    logic [AW-1:0] ram_addr_q, ram_addr_d;
    logic [DW-1:0] ram_data_q, ram_data_d;
    logic          ram_wren_q, ram_wren_d;
    logic [DW-1:0] rdata0_q, rdata0_d;
    logic [DW-1:0] rdata1_q, rdata1_d;
    logic          any_req;
    logic          win1;

    assign any_req = REQ0 | REQ1;

    // Winner selection: port 1 wins alone, or on contention when it was not served last
`ifdef MEM_ARB_FIXED_PRIO_EN
    assign win1 = REQ1 & ~REQ0;
`else
    assign win1 = REQ1 & (~REQ0 | ~last_q);
`endif

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: one access takes IDLE -> BUSY -> DONE
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (any_req) state_d = BUSY;
            BUSY:    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs: acknowledge is the DONE cycle steered by the latched winner
    always_comb begin
        ACK0 = (state_q == DONE) & ~gid_q;
        ACK1 = (state_q == DONE) & gid_q;
    end

    // Datapath next values: launch the grant in IDLE, capture read data leaving BUSY
    always_comb begin
        last_d     = last_q;
        gid_d      = gid_q;
        ram_addr_d = ram_addr_q;
        ram_data_d = ram_data_q;
        ram_wren_d = 1'b0;
        rdata0_d   = rdata0_q;
        rdata1_d   = rdata1_q;
        if (state_q == IDLE && any_req) begin
            gid_d      = win1;
            last_d     = win1;
            ram_addr_d = win1 ? ADDR1 : ADDR0;
            ram_data_d = win1 ? WDATA1 : WDATA0;
            ram_wren_d = win1 ? WREN1 : WREN0;
        end
        if (state_q == BUSY && !ram_wren_q) begin
            if (gid_q) rdata1_d = RAM_Q;
            else       rdata0_d = RAM_Q;
        end
    end

    // Datapath registers; reset leaves port 1 as last served so port 0 wins first
    always_ff @(posedge CLK) begin
        if (RST) begin
            last_q     <= 1'b1;
            gid_q      <= 1'b0;
            ram_addr_q <= '0;
            ram_data_q <= '0;
            ram_wren_q <= 1'b0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
        end else begin
            last_q     <= last_d;
            gid_q      <= gid_d;
            ram_addr_q <= ram_addr_d;
            ram_data_q <= ram_data_d;
            ram_wren_q <= ram_wren_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
        end
    end

    assign RAM_ADDR = ram_addr_q;
    assign RAM_DATA = ram_data_q;
    assign RAM_WREN = ram_wren_q;
    assign RDATA0   = rdata0_q;
    assign RDATA1   = rdata1_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: randomized and directed checks of ram_arbiter
// against a transaction-level model of grants and memory contents.
module tb_ram_arbiter;

    localparam int AW = 12;
    localparam int DW = 16;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          r_req [2];
    logic          rq_w  [2];
    logic [AW-1:0] rq_a  [2];
    logic [DW-1:0] rq_d  [2];
    logic          ACK0, ACK1;
    logic [DW-1:0] RDATA0, RDATA1;
    logic [AW-1:0] RAM_ADDR;
    logic [DW-1:0] RAM_DATA;
    logic          RAM_WREN;
    logic [DW-1:0] RAM_Q = '0;

    logic [DW-1:0] ram_mem [0:(1<<AW)-1];
    logic [DW-1:0] exp_mem [0:(1<<AW)-1];
    logic [DW-1:0] exp_rdata [2];
    int            last_m;
    int            checks = 0;
    int            errors = 0;

    ram_arbiter #(.AW(AW), .DW(DW)) dut (
        .CLK(CLK), .RST(RST),
        .REQ0(r_req[0]), .REQ1(r_req[1]),
        .WREN0(rq_w[0]), .WREN1(rq_w[1]),
        .ADDR0(rq_a[0]), .ADDR1(rq_a[1]),
        .WDATA0(rq_d[0]), .WDATA1(rq_d[1]),
        .ACK0(ACK0), .ACK1(ACK1),
        .RDATA0(RDATA0), .RDATA1(RDATA1),
        .RAM_ADDR(RAM_ADDR), .RAM_DATA(RAM_DATA),
        .RAM_WREN(RAM_WREN), .RAM_Q(RAM_Q)
    );

    always #5 CLK = ~CLK;

    // RAM clocked on the inverted clock
    always @(negedge CLK) begin
        if (RAM_WREN) ram_mem[RAM_ADDR] <= RAM_DATA;
        RAM_Q <= ram_mem[RAM_ADDR];
    end

    function automatic logic ack_of(input int p);
        return (p == 0) ? ACK0 : ACK1;
    endfunction

    function automatic logic [DW-1:0] rd_of(input int p);
        return (p == 0) ? RDATA0 : RDATA1;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        r_req[0] = 1'b0;
        r_req[1] = 1'b0;
        tick();
        tick();
        RST = 1'b0;
        exp_rdata[0] = '0;
        exp_rdata[1] = '0;
        last_m = 1;
    endtask

    // Drive one uncontended access; report latency and write strobes seen
    task automatic do_access(input int p, input logic w,
                             input logic [AW-1:0] a, input logic [DW-1:0] d,
                             output int lat, output int wr_cyc,
                             output logic [AW-1:0] wr_addr);
        lat = -1;
        wr_cyc = 0;
        wr_addr = '0;
        rq_w[p] = w;
        rq_a[p] = a;
        rq_d[p] = d;
        r_req[p] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (RAM_WREN) begin
                wr_cyc++;
                wr_addr = RAM_ADDR;
            end
            if (ack_of(p)) begin
                lat = k;
                r_req[p] = 1'b0;
                break;
            end
        end
        r_req[p] = 1'b0;
        tick();
        last_m = p;
        if (w) exp_mem[a] = d;
        else   exp_rdata[p] = exp_mem[a];
    endtask

    // Serve the preset requests of the active ports and check order, timing, data
    task automatic run_pair(input bit u0, input bit u1);
        int order [2];
        int n;
        int idx;
        int wr_seen;
        n = 0;
        if (u0 && u1) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
            order[0] = 0;
`else
            order[0] = (last_m == 1) ? 0 : 1;
`endif
            order[1] = 1 - order[0];
            n = 2;
        end else begin
            order[0] = u1 ? 1 : 0;
            n = 1;
        end
        r_req[0] = u0;
        r_req[1] = u1;
        idx = 0;
        wr_seen = 0;
        for (int k = 1; k <= 12 && idx < n; k++) begin
            tick();
            if (RAM_WREN) wr_seen++;
            checks++;
            if (ACK0 && ACK1) begin
                errors++;
                $display("FAIL ack_exclusive: ACK0=1 ACK1=1 required one-hot");
            end
            for (int p = 0; p < 2; p++) begin
                if (ack_of(p) && r_req[p]) begin
                    checks++;
                    if (p !== order[idx]) begin
                        errors++;
                        $display("FAIL grant_order: port %0d required %0d", p, order[idx]);
                    end
                    checks++;
                    if (k !== 2 + 3 * idx) begin
                        errors++;
                        $display("FAIL ack_latency: cycle %0d required %0d", k, 2 + 3 * idx);
                    end
                    if (rq_w[p]) exp_mem[rq_a[p]] = rq_d[p];
                    else         exp_rdata[p] = exp_mem[rq_a[p]];
                    last_m = p;
                    checks++;
                    if (rd_of(p) !== exp_rdata[p]) begin
                        errors++;
                        $display("FAIL rdata_p%0d: got %h required %h", p, rd_of(p), exp_rdata[p]);
                    end
                    checks++;
                    if (rd_of(1 - p) !== exp_rdata[1 - p]) begin
                        errors++;
                        $display("FAIL rdata_other_p%0d: got %h required %h", 1 - p, rd_of(1 - p), exp_rdata[1 - p]);
                    end
                    r_req[p] = 1'b0;
                    idx++;
                end
            end
        end
        checks++;
        if (idx !== n) begin
            errors++;
            $display("FAIL pair_timeout: acks %0d required %0d", idx, n);
        end
        checks++;
        if (wr_seen !== (u0 && rq_w[0]) + (u1 && rq_w[1])) begin
            errors++;
            $display("FAIL wren_cycles: got %0d required %0d", wr_seen, (u0 && rq_w[0]) + (u1 && rq_w[1]));
        end
        r_req[0] = 1'b0;
        r_req[1] = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        for (int k = 0; k < 10; k++) begin
            checks++;
            if ({ACK0, ACK1, RAM_WREN, RAM_ADDR, RAM_DATA, RDATA0, RDATA1} !== '0) begin
                errors++;
                $display("FAIL reset_outputs: ack=%b%b wren=%b addr=%h data=%h rd0=%h rd1=%h required all 0",
                         ACK0, ACK1, RAM_WREN, RAM_ADDR, RAM_DATA, RDATA0, RDATA1);
            end
            tick();
        end
    endtask

    task automatic test_write_read();
        int lat, wc;
        logic [AW-1:0] wa;
        do_access(0, 1'b1, 12'h123, 16'hBEEF, lat, wc, wa);
        checks++;
        if (lat !== 2) begin
            errors++;
            $display("FAIL wr_latency: got %0d required 2", lat);
        end
        checks++;
        if (wc !== 1 || wa !== 12'h123) begin
            errors++;
            $display("FAIL wr_strobe: cycles %0d addr %h required 1 and 123", wc, wa);
        end
        checks++;
        if (RDATA0 !== 16'h0000) begin
            errors++;
            $display("FAIL wr_rdata0: got %h required 0000", RDATA0);
        end
        do_access(0, 1'b0, 12'h123, 16'h0000, lat, wc, wa);
        checks++;
        if (lat !== 2 || wc !== 0) begin
            errors++;
            $display("FAIL rd_latency: lat %0d wren %0d required 2 and 0", lat, wc);
        end
        checks++;
        if (RDATA0 !== 16'hBEEF || RDATA1 !== 16'h0000) begin
            errors++;
            $display("FAIL rd_data: rd0 %h rd1 %h required BEEF and 0000", RDATA0, RDATA1);
        end
    endtask

    task automatic test_write_hold();
        int lat, wc;
        logic [AW-1:0] wa;
        do_access(0, 1'b1, 12'h124, 16'h1234, lat, wc, wa);
        checks++;
        if (RDATA0 !== 16'hBEEF) begin
            errors++;
            $display("FAIL hold_after_write: got %h required BEEF", RDATA0);
        end
        do_access(0, 1'b0, 12'h124, 16'h0000, lat, wc, wa);
        checks++;
        if (RDATA0 !== 16'h1234) begin
            errors++;
            $display("FAIL read_after_write: got %h required 1234", RDATA0);
        end
    endtask

    task automatic test_contention_held();
        int exp_p;
        bit exp_ack;
        do_reset();
        rq_w[0] = 1'b0; rq_a[0] = 12'h001; rq_d[0] = '0;
        rq_w[1] = 1'b0; rq_a[1] = 12'h002; rq_d[1] = '0;
        r_req[0] = 1'b1;
        r_req[1] = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            tick();
            exp_ack = (k % 3) == 2;
`ifdef MEM_ARB_FIXED_PRIO_EN
            exp_p = 0;
`else
            exp_p = ((k / 3) % 2 == 0) ? 0 : 1;
`endif
            checks++;
            if (ACK0 !== (exp_ack && exp_p == 0) || ACK1 !== (exp_ack && exp_p == 1)) begin
                errors++;
                $display("FAIL contention_ack c%0d: ACK0=%b ACK1=%b required port %0d ack %0b",
                         k, ACK0, ACK1, exp_p, exp_ack);
            end
            if (exp_ack) begin
                exp_rdata[exp_p] = exp_mem[rq_a[exp_p]];
                last_m = exp_p;
                checks++;
                if (rd_of(exp_p) !== exp_rdata[exp_p]) begin
                    errors++;
                    $display("FAIL contention_rdata c%0d: got %h required %h", k, rd_of(exp_p), exp_rdata[exp_p]);
                end
            end
        end
        r_req[0] = 1'b0;
        r_req[1] = 1'b0;
        tick();
    endtask

    task automatic test_top_address();
        int lat;
        do_reset();
        rq_w[1] = 1'b1; rq_a[1] = 12'hFFF; rq_d[1] = 16'h5A5A;
        r_req[1] = 1'b1;
        lat = -1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (ACK1) break;
        end
        checks++;
        if (ACK1 !== 1'b1) begin
            errors++;
            $display("FAIL top_write_ack: ACK1=%b required 1", ACK1);
        end
        exp_mem[12'hFFF] = 16'h5A5A;
        r_req[1] = 1'b0;
        rq_w[0] = 1'b0; rq_a[0] = 12'hFFF; rq_d[0] = '0;
        r_req[0] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (ACK0) begin
                lat = k;
                break;
            end
        end
        r_req[0] = 1'b0;
        checks++;
        if (lat !== 3 || RDATA0 !== 16'h5A5A) begin
            errors++;
            $display("FAIL top_read: lat %0d rd0 %h required 3 and 5A5A", lat, RDATA0);
        end
        exp_rdata[0] = 16'h5A5A;
        last_m = 0;
        tick();
    endtask

    task automatic test_reset_busy();
        do_reset();
        rq_w[1] = 1'b1; rq_a[1] = 12'h7F0; rq_d[1] = 16'h1111;
        r_req[1] = 1'b1;
        tick();
        checks++;
        if (RAM_WREN !== 1'b1 || RAM_ADDR !== 12'h7F0) begin
            errors++;
            $display("FAIL busy_strobe: wren %b addr %h required 1 and 7F0", RAM_WREN, RAM_ADDR);
        end
        RST = 1'b1;
        tick();
        RST = 1'b0;
        r_req[1] = 1'b0;
        checks++;
        if (RAM_WREN !== 1'b0 || ACK1 !== 1'b0 || ACK0 !== 1'b0) begin
            errors++;
            $display("FAIL busy_reset: wren %b ack1 %b ack0 %b required 0", RAM_WREN, ACK1, ACK0);
        end
        exp_rdata[0] = '0;
        exp_rdata[1] = '0;
        last_m = 1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (ACK1 !== 1'b0 || ACK0 !== 1'b0) begin
                errors++;
                $display("FAIL busy_no_ack: ack0 %b ack1 %b required 0", ACK0, ACK1);
            end
        end
        rq_w[0] = 1'b0; rq_a[0] = 12'h123;
        rq_w[1] = 1'b0; rq_a[1] = 12'h124;
        run_pair(1'b1, 1'b1);
    endtask

    task automatic test_random();
        int mode;
        for (int it = 0; it < 40; it++) begin
            mode = $urandom_range(0, 2);
            for (int p = 0; p < 2; p++) begin
                rq_w[p] = 1'($urandom_range(0, 1));
                rq_a[p] = 12'h0A0 + 12'($urandom_range(0, 3));
                rq_d[p] = 16'($urandom);
            end
            run_pair(mode != 1, mode != 0);
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            ram_mem[i] = '0;
            exp_mem[i] = '0;
        end
        for (int p = 0; p < 2; p++) begin
            r_req[p] = 1'b0;
            rq_w[p] = 1'b0;
            rq_a[p] = '0;
            rq_d[p] = '0;
        end
        test_reset();
        test_write_read();
        test_write_hold();
        test_contention_held();
        test_top_address();
        test_reset_busy();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
